// File: rtl/param_shift_reg.sv
// Parameterised shift register with shift-up/down, rotate and parallel load,
// plus a fill counter and a pattern match flag driven from registered state.
module param_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int FW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pdata,
    input  logic [WIDTH-1:0] pattern,
    output logic [WIDTH-1:0] q,
    output logic             sout_hi,
    output logic             sout_lo,
    output logic [FW-1:0]    fill,
    output logic             full,
    output logic             match
);

    typedef enum logic [1:0] {
        MODE_SHIFT_UP   = 2'b00,
        MODE_SHIFT_DOWN = 2'b01,
        MODE_ROTATE_UP  = 2'b10,
        MODE_LOAD       = 2'b11
    } mode_t;

    localparam logic [FW-1:0] FILL_MAX = FW'(WIDTH);

    logic [WIDTH-1:0] q_next;
    logic [FW-1:0]    fill_next;
    logic [FW-1:0]    fill_inc;
    mode_t            mode_sel;

    assign mode_sel = mode_t'(mode);
    // Serial shifts count one more valid bit, saturating once the register is full.
    assign fill_inc = (fill == FILL_MAX) ? FILL_MAX : fill + FW'(1);

    always_comb begin
        q_next    = q;
        fill_next = fill;
        if (clr) begin
            q_next    = '0;
            fill_next = '0;
        end else if (en) begin
            case (mode_sel)
                MODE_SHIFT_UP: begin
                    q_next    = {q[WIDTH-2:0], sin};
                    fill_next = fill_inc;
                end
                MODE_SHIFT_DOWN: begin
                    q_next    = {sin, q[WIDTH-1:1]};
                    fill_next = fill_inc;
                end
                MODE_ROTATE_UP: begin
                    q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                end
                MODE_LOAD: begin
                    q_next    = pdata;
                    fill_next = FILL_MAX;
                end
                default: begin
                    q_next    = q;
                    fill_next = fill;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            fill <= '0;
        end else begin
            q    <= q_next;
            fill <= fill_next;
        end
    end

    assign sout_hi = q[WIDTH-1];
    assign sout_lo = q[0];
    assign full    = (fill == FILL_MAX);
    assign match   = full && (q == pattern);

endmodule

// File: doc/param_shift_reg.md
PARAM_SHIFT_REG -- requirements
Module: param_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 8, register length in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: clr  input  1  synchronous clear, active-high.
REQ-005 Port: en  input  1  advance enable; state holds when low.
REQ-006 Port: mode  input  2  operation select: 00 shift-up, 01 shift-down, 10 rotate-up, 11 parallel load.
REQ-007 Port: sin  input  1  serial data in.
REQ-008 Port: pdata  input  WIDTH  parallel load data.
REQ-009 Port: pattern  input  WIDTH  compare value for match.
REQ-010 Port: q  output  WIDTH  register contents.
REQ-011 Port: sout_hi  output  1  q[WIDTH-1].
REQ-012 Port: sout_lo  output  1  q[0].
REQ-013 Port: fill  output  clog2(WIDTH+1)  count of valid bits shifted in since last clear/reset.
REQ-014 Port: full  output  1  high when fill equals WIDTH.
REQ-015 Port: match  output  1  high when full and q equals pattern.

Function
REQ-016 Update priority at each rising clk edge SHALL be: clr, then en=0 (hold), then mode.
REQ-017 clr=1 SHALL set q to 0 and fill to 0 at the edge, regardless of en and mode.
REQ-018 Shift-up (00) SHALL load q <= {q[WIDTH-2:0], sin}; bit 0 receives sin, each bit moves one place toward MSB, q[WIDTH-1] is discarded.
REQ-019 Shift-down (01) SHALL load q <= {sin, q[WIDTH-1:1]}; q[0] is discarded.
REQ-020 Rotate-up (10) SHALL load q <= {q[WIDTH-2:0], q[WIDTH-1]}; sin ignored; fill unchanged.
REQ-021 Parallel load (11) SHALL load q <= pdata and set fill to WIDTH in the same edge; sin ignored.
REQ-022 Shift-up and shift-down SHALL increment fill by 1 per enabled edge, saturating at WIDTH (no wrap).
REQ-023 en=0 with clr=0 SHALL hold q and fill unchanged regardless of mode, sin, pdata.
REQ-024 sout_hi, sout_lo, full SHALL be combinational decodes of registered state only; latency from edge to visible value is zero cycles after the edge.
REQ-025 match SHALL be combinational from registered state and pattern; a pattern change is reflected without a clock edge.
REQ-026 Mode changes between consecutive edges SHALL take effect on the next edge with no idle cycle.
REQ-027 With WIDTH=8, mode=00, en=1, clr=0, behaviour SHALL be bit-identical in q to an 8-stage serial-in shift chain with sin into bit 0.

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock edge, force q=0, fill=0; hence sout_hi=0, sout_lo=0, full=0, match=0.
REQ-029 Reset assertion mid-operation (any mode, any fill) SHALL discard all state; no partial update from a coincident edge.
REQ-030 After rst_n deasserts, the first rising edge SHALL perform a normal update per REQ-016.

Verification
REQ-031 WIDTH=8: shift-up, sin=1 once then 0 for 7 edges -> q=0x80, sout_hi=1, fill=8, full=1 after 8th edge; fill=7, full=0 after 7th.
REQ-032 Load pdata=0xA5, then 3 rotate-up edges -> q=0x4B, 0x96, 0x2D; fill stays 8; pattern=0x2D -> match=1 only after third edge.
REQ-033 From reset, shift-down with sin=1 for 4 edges -> q=0xF0, fill=4, full=0, sout_lo=0; 6 further edges -> q=0xFF, fill=8 (saturated).
REQ-034 clr=1 with en=1, mode=11, pdata=0xFF -> q=0x00, fill=0; en=0 with mode=11 -> q unchanged.
REQ-035 rst_n pulsed low between edges while q=0x5A, fill=8 -> q=0, fill=0, match=0 before next edge; next edge shift-up sin=1 -> q=0x01, fill=1.
REQ-036 Repeat REQ-031 and REQ-033 at WIDTH=2 and WIDTH=32 -> same behaviour scaled, fill saturates at WIDTH.
